ex_div_ctrl: RTL and testbench
==============================

Name: ex_div_ctrl

Overview:
- Execute-stage sequencer placed directly upstream of the 24-bit iterative divider (`div`).
- Accepts a divide request from the EX pipeline and latches the operands.
- Drives the divider start/annul handshake, stalls the pipeline while the divider is busy, and captures quotient/remainder for write-back.
- Handles divide-by-zero locally, without starting the divider. Also handles pipeline flush and a watchdog timeout.

Parameters:
- WIDTH, 24, operand/quotient/remainder width.
- TIMEOUT, 64, maximum BUSY cycles allowed before the divide is abandoned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low (rst==0 resets on clk rising edge).
- div_req_i  input  1  EX stage holds a divide instruction; stays high until result_valid_o.
- signed_i  input  1  1 = signed divide.
- op1_i  input  WIDTH  dividend.
- op2_i  input  WIDTH  divisor.
- flush_i  input  1  pipeline flush; cancels any in-flight divide.
- div_ready_i  input  1  divider ready pulse; quotient/remainder valid in this cycle.
- div_quotient_i  input  WIDTH  divider quotient.
- div_remainder_i  input  WIDTH  divider remainder.
- div_start_o  output  1  divider start; held high for the whole BUSY state.
- div_annul_o  output  1  one-cycle divider abort pulse.
- div_signed_o  output  1  latched signed_i.
- div_op1_o  output  WIDTH  latched dividend.
- div_op2_o  output  WIDTH  latched divisor.
- stall_o  output  1  hold the EX/MEM pipeline.
- result_valid_o  output  1  one-cycle pulse; quotient_o/remainder_o valid.
- quotient_o  output  WIDTH  captured quotient.
- remainder_o  output  WIDTH  captured remainder.
- div_by_zero_o  output  1  qualifies result_valid_o: divisor was zero.
- timeout_o  output  1  one-cycle pulse: divide abandoned by the watchdog.

Behaviour:

Reset (rst==0 at a clk edge):
- State returns to IDLE.
- All registered outputs and latched operands become 0.
- Watchdog counter becomes 0.
- Reset overrides every other input, including mid-BUSY.
- No annul pulse is issued on reset; the divider is reset by the same rst.

States: IDLE, BUSY, DONE, DZERO.

IDLE:
- If div_req_i=1 and flush_i=0, latch signed_i, op1_i and op2_i.
- If op2_i==0, go to DZERO; otherwise go to BUSY and assert div_start_o from the next cycle.
- A flush_i=1 in the same cycle suppresses acceptance.

BUSY:
- div_start_o=1; watchdog increments each cycle.
- flush_i=1 has priority over div_ready_i. It causes:
  - div_annul_o=1 for one cycle;
  - div_start_o=0 next cycle;
  - return to IDLE with no result_valid_o.
- Otherwise div_ready_i=1 captures div_quotient_i/div_remainder_i into quotient_o/remainder_o, drops div_start_o and goes to DONE.
- Otherwise, when the watchdog reaches TIMEOUT-1 with no div_ready_i, the controller:
  - pulses div_annul_o and timeout_o;
  - sets quotient_o and remainder_o to 0;
  - goes to DONE, so the pipeline is released.

DONE:
- result_valid_o=1 for exactly one cycle.
- Any div_req_i seen in DONE is ignored; this prevents re-issue before the pipeline advances.
- Always goes to IDLE next.
- A flush_i in DONE still lets the pulse occur; write-back discards it.

DZERO:
- quotient_o = all ones; remainder_o = latched op1 (unsigned and signed alike).
- div_by_zero_o=1 and result_valid_o=1 for one cycle.
- Goes to IDLE next.
- The divider is never started.

stall_o (combinational): high when (IDLE and div_req_i and not flush_i) or state is BUSY. It is low in DONE and DZERO, so the pipeline advances in the same cycle result_valid_o is high.

Latency from acceptance to result_valid_o:
- divider latency + 2 cycles;
- 2 cycles for divide-by-zero.

Operand registers hold their value from acceptance until the next acceptance.

Test Plan:
- Unsigned 703/37: rst low 2 cycles, then div_req_i=1, op1=703, op2=37, signed=0, against a behavioural divider with ready 10 cycles after start.
  - div_start_o high 10 cycles; stall_o high throughout.
  - result_valid_o pulses once with quotient_o=19, remainder_o=0.
  - stall_o falls in the same cycle.
- Signed -100/7 (op1=24'hFFFF9C, op2=7, signed=1): div_signed_o=1 and the operands are passed unchanged.
  - Captured quotient_o=24'hFFFFF2 (-14), remainder_o=24'hFFFFFE (-2) from the model.
- Divide-by-zero, op1=100, op2=0: div_start_o never rises.
  - Two cycles later result_valid_o=1, div_by_zero_o=1, quotient_o=24'hFFFFFF, remainder_o=100.
- Flush mid-divide: flush_i=1 on the 4th BUSY cycle.
  - div_annul_o pulses once; div_start_o low next cycle.
  - No result_valid_o; stall_o low; state back to IDLE.
  - The next request is accepted normally.
- Timeout with the model never asserting ready, TIMEOUT=64:
  - After 64 BUSY cycles, div_annul_o and timeout_o pulse.
  - result_valid_o then pulses with quotient_o=0 and remainder_o=0.
- Reset mid-BUSY, and ready coincident with flush:
  - rst=0 on BUSY cycle 3 clears all outputs next edge, with no annul pulse.
  - In a separate run, div_ready_i and flush_i high in the same cycle: flush wins, giving an annul pulse and no result_valid_o.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// Execute-stage sequencer for the iterative divider: latches operands, drives the
// start/annul handshake, stalls EX while busy and captures the result for write-back.
module ex_div_ctrl #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_req_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             flush_i,
  input  logic             div_ready_i,
  input  logic [WIDTH-1:0] div_quotient_i,
  input  logic [WIDTH-1:0] div_remainder_i,
  output logic             div_start_o,
  output logic             div_annul_o,
  output logic             div_signed_o,
  output logic [WIDTH-1:0] div_op1_o,
  output logic [WIDTH-1:0] div_op2_o,
  output logic             stall_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DZERO} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wdog_q;
  logic             accept, capture, expire, annul;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    annul   = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_req_i && !flush_i) begin
          accept  = 1'b1;
          state_d = (op2_i == '0) ? DZERO : BUSY;
        end
      end
      BUSY: begin
        // Flush outranks a coincident ready; the watchdog only fires when neither is present.
        if (flush_i) begin
          annul   = 1'b1;
          state_d = IDLE;
        end else if (div_ready_i) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          annul   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      DZERO:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      quotient_o   <= '0;
      remainder_o  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BUSY && state_d == BUSY) begin
        wdog_q <= wdog_q + 1'b1;
      end else begin
        wdog_q <= '0;
      end
      if (accept) begin
        div_signed_o <= signed_i;
        div_op1_o    <= op1_i;
        div_op2_o    <= op2_i;
        // Divide-by-zero result is loaded here so it is already valid in DZERO.
        if (op2_i == '0) begin
          quotient_o  <= '1;
          remainder_o <= op1_i;
        end
      end
      if (capture) begin
        quotient_o  <= div_quotient_i;
        remainder_o <= div_remainder_i;
      end
      if (expire) begin
        quotient_o  <= '0;
        remainder_o <= '0;
      end
    end
  end

  // Abort pulses are suppressed during reset; the divider is reset by the same rst.
  assign div_annul_o    = annul & rst;
  assign timeout_o      = expire & rst;
  assign div_start_o    = (state_q == BUSY);
  assign stall_o        = accept || (state_q == BUSY);
  assign result_valid_o = (state_q == DONE) || (state_q == DZERO);
  assign div_by_zero_o  = (state_q == DZERO);

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl; the divider is emulated step by step from the stimulus.
module tb_ex_div_ctrl;

  logic        clk;
  logic        rst;
  logic        div_req_i;
  logic        signed_i;
  logic [23:0] op1_i;
  logic [23:0] op2_i;
  logic        flush_i;
  logic        div_ready_i;
  logic [23:0] div_quotient_i;
  logic [23:0] div_remainder_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [23:0] div_op1_o;
  logic [23:0] div_op2_o;
  logic        stall_o;
  logic        result_valid_o;
  logic [23:0] quotient_o;
  logic [23:0] remainder_o;
  logic        div_by_zero_o;
  logic        timeout_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  ex_div_ctrl #(.WIDTH(24), .TIMEOUT(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .div_req_i       (div_req_i),
    .signed_i        (signed_i),
    .op1_i           (op1_i),
    .op2_i           (op2_i),
    .flush_i         (flush_i),
    .div_ready_i     (div_ready_i),
    .div_quotient_i  (div_quotient_i),
    .div_remainder_i (div_remainder_i),
    .div_start_o     (div_start_o),
    .div_annul_o     (div_annul_o),
    .div_signed_o    (div_signed_o),
    .div_op1_o       (div_op1_o),
    .div_op2_o       (div_op2_o),
    .stall_o         (stall_o),
    .result_valid_o  (result_valid_o),
    .quotient_o      (quotient_o),
    .remainder_o     (remainder_o),
    .div_by_zero_o   (div_by_zero_o),
    .timeout_o       (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete divide: ready arrives in BUSY cycle 'lat' with the given result.
  task automatic do_div(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input logic s, input int unsigned lat,
                        input logic [23:0] q, input logic [23:0] r);
    @(negedge clk);
    div_req_i = 1'b1; op1_i = a; op2_i = b; signed_i = s;
    #1;
    chk1({tag, ".acc_stall"}, stall_o, 1'b1);
    chk1({tag, ".acc_start"}, div_start_o, 1'b0);
    for (int unsigned i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == lat) begin
        div_ready_i = 1'b1; div_quotient_i = q; div_remainder_i = r;
      end
      #1;
      chk1({tag, ".busy_start"}, div_start_o, 1'b1);
      chk1({tag, ".busy_stall"}, stall_o, 1'b1);
      chk1({tag, ".busy_rv"}, result_valid_o, 1'b0);
    end
    chkw({tag, ".op1"}, div_op1_o, a);
    chkw({tag, ".op2"}, div_op2_o, b);
    chk1({tag, ".signed"}, div_signed_o, s);
    @(negedge clk);
    div_ready_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;
    #1;
    chk1({tag, ".done_rv"}, result_valid_o, 1'b1);
    chkw({tag, ".done_q"}, quotient_o, q);
    chkw({tag, ".done_r"}, remainder_o, r);
    chk1({tag, ".done_stall"}, stall_o, 1'b0);
    chk1({tag, ".done_start"}, div_start_o, 1'b0);
    chk1({tag, ".done_dbz"}, div_by_zero_o, 1'b0);
    @(negedge clk);
    div_req_i = 1'b0;
    #1;
    chk1({tag, ".idle_rv"}, result_valid_o, 1'b0);
    chk1({tag, ".idle_stall"}, stall_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0; div_req_i = 1'b0; signed_i = 1'b0; op1_i = '0; op2_i = '0;
    flush_i = 1'b0; div_ready_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;

    // Reset for two edges
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rst.start", div_start_o, 1'b0);
    chk1("rst.stall", stall_o, 1'b0);
    chk1("rst.rv", result_valid_o, 1'b0);
    chkw("rst.q", quotient_o, 24'd0);
    chkw("rst.op1", div_op1_o, 24'd0);
    @(negedge clk);
    rst = 1'b1;

    // Unsigned 703/37 = 19 r 0, ready in BUSY cycle 10
    do_div("udiv", 24'd703, 24'd37, 1'b0, 10, 24'd19, 24'd0);

    // Signed -100/7 = -14 r -2
    do_div("sdiv", 24'hFFFF9C, 24'd7, 1'b1, 10, 24'hFFFFF2, 24'hFFFFFE);

    // Divide by zero
    @(negedge clk);
    div_req_i = 1'b1; op1_i = 24'd100; op2_i = 24'd0; signed_i = 1'b0;
    #1;
    chk1("dz.acc_stall", stall_o, 1'b1);
    chk1("dz.acc_start", div_start_o, 1'b0);
    @(negedge clk);
    #1;
    chk1("dz.rv", result_valid_o, 1'b1);
    chk1("dz.dbz", div_by_zero_o, 1'b1);
    chkw("dz.q", quotient_o, 24'hFFFFFF);
    chkw("dz.r", remainder_o, 24'd100);
    chk1("dz.start", div_start_o, 1'b0);
    chk1("dz.stall", stall_o, 1'b0);
    @(negedge clk);
    div_req_i = 1'b0;
    #1;
    chk1("dz.idle_rv", result_valid_o, 1'b0);
    chk1("dz.idle_dbz", div_by_zero_o, 1'b0);
    chk1("dz.idle_start", div_start_o, 1'b0);

    // Flush on the 4th BUSY cycle
    @(negedge clk);
    div_req_i = 1'b1; op1_i = 24'd50; op2_i = 24'd5; signed_i = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) flush_i = 1'b1;
      #1;
      chk1("fl.busy_start", div_start_o, 1'b1);
      chk1("fl.annul", div_annul_o, i == 4);
    end
    @(negedge clk);
    flush_i = 1'b0; div_req_i = 1'b0;
    #1;
    chk1("fl.post_start", div_start_o, 1'b0);
    chk1("fl.post_annul", div_annul_o, 1'b0);
    chk1("fl.post_rv", result_valid_o, 1'b0);
    chk1("fl.post_stall", stall_o, 1'b0);
    @(negedge clk);
    #1;
    chk1("fl.post2_rv", result_valid_o, 1'b0);
    do_div("refill", 24'd50, 24'd7, 1'b0, 3, 24'd7, 24'd1);

    // Watchdog timeout: ready never arrives
    @(negedge clk);
    div_req_i = 1'b1; op1_i = 24'd9; op2_i = 24'd3;
    for (int unsigned i = 1; i <= 64; i++) begin
      @(negedge clk);
      #1;
      chk1("to.start", div_start_o, 1'b1);
      chk1("to.annul", div_annul_o, i == 64);
      chk1("to.timeout", timeout_o, i == 64);
    end
    @(negedge clk);
    #1;
    chk1("to.rv", result_valid_o, 1'b1);
    chkw("to.q", quotient_o, 24'd0);
    chkw("to.r", remainder_o, 24'd0);
    chk1("to.post_timeout", timeout_o, 1'b0);
    chk1("to.post_annul", div_annul_o, 1'b0);
    chk1("to.post_start", div_start_o, 1'b0);
    @(negedge clk);
    div_req_i = 1'b0;
    #1;
    chk1("to.idle_rv", result_valid_o, 1'b0);

    // Reset during BUSY cycle 3
    @(negedge clk);
    div_req_i = 1'b1; op1_i = 24'd703; op2_i = 24'd37; signed_i = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      #1;
      chk1("rb.annul", div_annul_o, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1; div_req_i = 1'b0; signed_i = 1'b0;
    #1;
    chk1("rb.start", div_start_o, 1'b0);
    chk1("rb.stall", stall_o, 1'b0);
    chk1("rb.annul_after", div_annul_o, 1'b0);
    chk1("rb.rv", result_valid_o, 1'b0);
    chk1("rb.signed", div_signed_o, 1'b0);
    chkw("rb.op1", div_op1_o, 24'd0);
    chkw("rb.op2", div_op2_o, 24'd0);

    // Ready coincident with flush: flush wins
    @(negedge clk);
    div_req_i = 1'b1; op1_i = 24'd20; op2_i = 24'd4;
    for (int unsigned i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 3) begin
        flush_i = 1'b1; div_ready_i = 1'b1; div_quotient_i = 24'd5; div_remainder_i = 24'd3;
      end
      #1;
      chk1("rf.annul", div_annul_o, i == 3);
    end
    @(negedge clk);
    flush_i = 1'b0; div_ready_i = 1'b0; div_req_i = 1'b0;
    div_quotient_i = '0; div_remainder_i = '0;
    #1;
    chk1("rf.rv", result_valid_o, 1'b0);
    chk1("rf.start", div_start_o, 1'b0);
    chk1("rf.stall", stall_o, 1'b0);
    chkw("rf.q", quotient_o, 24'd0);
    chkw("rf.r", remainder_o, 24'd0);
    @(negedge clk);
    #1;
    chk1("rf.rv2", result_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
